// File: rtl/i2c_apb_read_mux.sv
// APB read-side decoder for the I2C block: registered read data, RX FIFO pop strobe,
// and the clear-on-read sticky event bits that drive the interrupt.
module i2c_apb_read_mux #(
  parameter logic [11:0] A_RXDATA   = 12'h000,
  parameter logic [11:0] A_STATUS   = 12'h004,
  parameter logic [11:0] A_CONTROL  = 12'h008,
  parameter logic [11:0] A_CLKDIVHI = 12'h00C,
  parameter logic [11:0] A_CLKDIVLO = 12'h010
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  output logic [31:0] prdata,
  input  logic [7:0]  rxData,
  input  logic        rxEmpty,
  output logic        rxDataRead,
  input  logic [7:0]  control,
  input  logic [15:0] clkdivhi,
  input  logic [15:0] clkdivlo,
  input  logic        busBusy,
  input  logic        txEmpty,
  input  logic        evTxDone,
  input  logic        evNack,
  input  logic        evArbLost,
  input  logic        evRxOvf,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] prdata_q, prdata_d;
  logic        rx_pop_q, rx_pop_d;
  logic        status_rd_q, status_rd_d;
  logic [3:0]  sticky_q, sticky_d;
  logic        irq_q, irq_d;

  logic        setup_rd;
  logic        access_ph;
  logic        clear_sticky;
  logic [31:0] rd_word;
  logic [3:0]  ev_vec;

  assign setup_rd  = psel & ~pwrite & ~penable;
  assign access_ph = psel & penable;
  assign ev_vec    = {evRxOvf, evArbLost, evNack, evTxDone};

  always_comb begin
    rd_word = 32'h0;
    if (paddr == A_RXDATA)        rd_word = rxEmpty ? 32'h0 : {24'b0, rxData};
    else if (paddr == A_STATUS)   rd_word = {26'b0, busBusy, txEmpty, sticky_q};
    else if (paddr == A_CONTROL)  rd_word = {24'b0, control};
    else if (paddr == A_CLKDIVHI) rd_word = {16'b0, clkdivhi};
    else if (paddr == A_CLKDIVLO) rd_word = {16'b0, clkdivlo};
  end

  // A new read setup restarts the transfer from any state; the pop is launched at the
  // setup edge so it lines up with the first access-phase cycle and cannot repeat.
  always_comb begin
    state_d     = state_q;
    prdata_d    = prdata_q;
    rx_pop_d    = 1'b0;
    status_rd_d = status_rd_q;
    if (setup_rd) begin
      state_d     = SETUP;
      prdata_d    = rd_word;
      rx_pop_d    = (paddr == A_RXDATA) & ~rxEmpty;
      status_rd_d = (paddr == A_STATUS);
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SETUP:   state_d = access_ph ? ACCESS : IDLE;
        ACCESS:  state_d = access_ph ? ACCESS : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Event sets take priority over the read clear so no pulse is ever lost.
  always_comb begin
    clear_sticky = (state_q == SETUP) & access_ph & status_rd_q;
    sticky_d     = (clear_sticky ? 4'b0 : sticky_q) | ev_vec;
    irq_d        = |(sticky_d & control[7:4]);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      prdata_q    <= 32'h0;
      rx_pop_q    <= 1'b0;
      status_rd_q <= 1'b0;
      sticky_q    <= 4'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prdata_q    <= prdata_d;
      rx_pop_q    <= rx_pop_d;
      status_rd_q <= status_rd_d;
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
    end
  end

  assign prdata     = prdata_q;
  assign rxDataRead = rx_pop_q;
  assign irq        = irq_q;

endmodule
